// File: rtl/parser_pkg.sv
// Shared types and constants for the parser rule configuration path.
// PARSER_CFG_READBACK_EN enables the rule readback window.
package parser_pkg;

    localparam int LAYER_NUM  = 4;
    localparam int RULE_NUM   = 8;
    localparam int CFG_ADDR_W = 8;
    localparam int CFG_DATA_W = 32;
    localparam int RULE_WORDS = 8;
    localparam int RULE_W     = 231;
    localparam int LAYER_W    = $clog2(LAYER_NUM);
    localparam int IDX_W      = $clog2(RULE_NUM);
    localparam int SLOT_W     = LAYER_W + IDX_W;

    localparam logic [CFG_ADDR_W-1:0] ADDR_CMD     = 8'h10;
    localparam logic [CFG_ADDR_W-1:0] ADDR_STATUS  = 8'h11;
    localparam logic [CFG_ADDR_W-1:0] ADDR_CNT     = 8'h12;
    localparam logic [CFG_ADDR_W-1:0] ADDR_ERR_CLR = 8'h13;
    localparam logic [CFG_ADDR_W-1:0] ADDR_RB_BASE = 8'h20;

    localparam logic [SLOT_W-1:0] SWEEP_LAST = SLOT_W'(LAYER_NUM * RULE_NUM - 1);

    typedef struct packed {
        logic              typeRule_valid;
        logic [RULE_W-2:0] body;
    } type_rule_t;

    typedef struct packed {
        logic [LAYER_W-1:0] layer;
        logic [IDX_W-1:0]   idx;
        logic               commit;
        logic               clear_all;
    } cfg_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        SWEEP
    } cfg_state_e;

endpackage

// File: rtl/parser_rule_cfg_ctrl.sv
// Host register file and sequencer loading rules into the parser tables.
// PARSER_CFG_READBACK_EN adds RO copies of the last written rule at 0x20-0x27.
module parser_rule_cfg_ctrl
    import parser_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cfg_valid,
    input  logic                  i_cfg_wr,
    input  logic [CFG_ADDR_W-1:0] i_cfg_addr,
    input  logic [CFG_DATA_W-1:0] i_cfg_wdata,
    output logic                  o_cfg_rvalid,
    output logic [CFG_DATA_W-1:0] o_cfg_rdata,
    output logic                  o_rule_wr_valid,
    input  logic                  i_rule_wr_ready,
    output logic [LAYER_W-1:0]    o_rule_wr_layer,
    output logic [IDX_W-1:0]      o_rule_wr_idx,
    output type_rule_t            o_rule_wr_data,
    output logic                  o_busy
);

    typedef logic [RULE_WORDS-1:0][CFG_DATA_W-1:0] words_t;

    cfg_state_e            state_q, state_d;
    words_t                shadow_q, shadow_d;
    logic [LAYER_W-1:0]    layer_q, layer_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  err_busy_q, err_busy_d;
    logic                  err_addr_q, err_addr_d;
    logic                  err_cmd_q, err_cmd_d;
    logic                  rvalid_q, rvalid_d;
    logic [CFG_DATA_W-1:0] rdata_q, rdata_d;
`ifdef PARSER_CFG_READBACK_EN
    words_t                rb_q, rb_d;
`endif

    logic       busy;
    logic       accept;
    logic       is_shadow;
    logic       is_rb;
    logic       mapped;
    cfg_cmd_t   cmd;
    logic [RULE_W-1:0] rule_img;

    assign busy      = (state_q != IDLE);
    assign accept    = busy & i_rule_wr_ready;
    assign is_shadow = (i_cfg_addr[CFG_ADDR_W-1:3] == '0);
    assign cmd       = {i_cfg_wdata[1:0], i_cfg_wdata[4:2],
                        i_cfg_wdata[8], i_cfg_wdata[9]};
    assign rule_img  = (state_q == WRITE) ? shadow_q[RULE_W-1:0] : '0;

`ifdef PARSER_CFG_READBACK_EN
    assign is_rb = (i_cfg_addr[CFG_ADDR_W-1:3] == ADDR_RB_BASE[CFG_ADDR_W-1:3]);
`else
    assign is_rb = 1'b0;
`endif

    assign mapped = is_shadow | is_rb
                  | (i_cfg_addr[CFG_ADDR_W-1:2] == ADDR_CMD[CFG_ADDR_W-1:2]);

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        layer_d    = layer_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        err_busy_d = err_busy_q;
        err_addr_d = err_addr_q;
        err_cmd_d  = err_cmd_q;
        rvalid_d   = 1'b0;
        rdata_d    = '0;
`ifdef PARSER_CFG_READBACK_EN
        rb_d       = rb_q;
        if (accept)
            rb_d = words_t'(rule_img);
`endif

        unique case (state_q)
            WRITE: begin
                if (i_rule_wr_ready) begin
                    state_d = IDLE;
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            SWEEP: begin
                if (i_rule_wr_ready) begin
                    {layer_d, idx_d} = {layer_q, idx_q} + SLOT_W'(1);
                    if ({layer_q, idx_q} == SWEEP_LAST)
                        state_d = IDLE;
                end
            end
            default: ;
        endcase

        if (i_cfg_valid) begin
            if (!mapped)
                err_addr_d = 1'b1;
            if (!i_cfg_wr) begin
                rvalid_d = 1'b1;
                if (is_shadow)
                    rdata_d = shadow_q[i_cfg_addr[2:0]];
                else if (i_cfg_addr == ADDR_STATUS)
                    rdata_d = {28'd0, err_cmd_q, err_addr_q, err_busy_q, busy};
                else if (i_cfg_addr == ADDR_CNT)
                    rdata_d = {16'd0, cnt_q};
`ifdef PARSER_CFG_READBACK_EN
                else if (is_rb)
                    rdata_d = rb_q[i_cfg_addr[2:0]];
`endif
            end else if (busy && (is_shadow || i_cfg_addr == ADDR_CMD)) begin
                // shadow stays frozen while a write is in flight
                err_busy_d = 1'b1;
            end else if (is_shadow) begin
                shadow_d[i_cfg_addr[2:0]] = i_cfg_wdata;
            end else if (i_cfg_addr == ADDR_CMD) begin
                if (cmd.commit == cmd.clear_all) begin
                    err_cmd_d = 1'b1;
                end else if (cmd.commit) begin
                    state_d = WRITE;
                    layer_d = cmd.layer;
                    idx_d   = cmd.idx;
                end else begin
                    state_d = SWEEP;
                    layer_d = '0;
                    idx_d   = '0;
                end
            end else if (i_cfg_addr == ADDR_ERR_CLR) begin
                if (i_cfg_wdata[1]) err_busy_d = 1'b0;
                if (i_cfg_wdata[2]) err_addr_d = 1'b0;
                if (i_cfg_wdata[3]) err_cmd_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            shadow_q   <= '0;
            layer_q    <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            err_busy_q <= 1'b0;
            err_addr_q <= 1'b0;
            err_cmd_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
`ifdef PARSER_CFG_READBACK_EN
            rb_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            layer_q    <= layer_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            err_busy_q <= err_busy_d;
            err_addr_q <= err_addr_d;
            err_cmd_q  <= err_cmd_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
`ifdef PARSER_CFG_READBACK_EN
            rb_q       <= rb_d;
`endif
        end
    end

    assign o_cfg_rvalid    = rvalid_q;
    assign o_cfg_rdata     = rdata_q;
    assign o_rule_wr_valid = busy;
    assign o_busy          = busy;
    assign o_rule_wr_layer = layer_q;
    assign o_rule_wr_idx   = idx_q;
    assign o_rule_wr_data  = rule_img;

endmodule
